// File: rtl/pi_digit_scroller.sv
// Buffers a stream of BCD digits in a small FIFO and shifts one into an
// 8-digit display window on every scroll tick, feeding the seven-segment scanner.
module pi_digit_scroller #(
    parameter int         DEPTH      = 8,
    parameter int         SCROLL_DIV = 25000000,
    parameter int         COUNT_W    = 16,
    parameter logic [3:0] BLANK      = 4'd10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pause,
    input  logic                     in_valid,
    input  logic [3:0]               in_digit,
    output logic                     in_ready,
    output logic [31:0]              digits_o,
    output logic [COUNT_W-1:0]       count_o,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     err_o
);

    localparam int                 PTR_W     = $clog2(DEPTH);
    localparam int                 LVL_W     = PTR_W + 1;
    localparam int                 PS_W      = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [PS_W-1:0]    PS_MAX    = PS_W'(SCROLL_DIV - 1);
    localparam logic [LVL_W-1:0]   FULL      = LVL_W'(DEPTH);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    logic [3:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PS_W-1:0]  prescaler;
    logic             push;
    logic             bad_digit;
    logic             store;
    logic             tick;
    logic             pop;

    // Occupancy is registered, so a pop while full frees a slot only next cycle.
    assign in_ready  = (fifo_level != FULL);
    assign push      = in_valid && in_ready;
    assign bad_digit = (in_digit > 4'd9);
    assign store     = push && !bad_digit;
    assign tick      = (prescaler == PS_MAX) && !pause;
    assign pop       = tick && (fifo_level != '0);

    // NOTE: every register uses <= so all updates see the pre-edge state.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
        end else if (!pause) begin
            prescaler <= (prescaler == PS_MAX) ? '0 : prescaler + PS_W'(1);
        end
    end

    // NOTE: the storage array is not reset; pointers and level define which entries are live.
    always_ff @(posedge clk) begin
        if (store && !rst) begin
            mem[wr_ptr] <= in_digit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (store && !pop) begin
                fifo_level <= fifo_level + LVL_W'(1);
            end else if (pop && !store) begin
                fifo_level <= fifo_level - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digits_o <= {8{BLANK}};
            count_o  <= '0;
        end else if (pop) begin
            digits_o <= {digits_o[27:0], mem[rd_ptr]};
            if (count_o != COUNT_MAX) begin
                count_o <= count_o + COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if (push && bad_digit) begin
            err_o <= 1'b1;
        end
    end

endmodule

// File: doc/pi_digit_scroller.md
Name: pi_digit_scroller

Overview:
- Upstream feeder for the 8-digit seven-segment scanner.
- Accepts a stream of decimal digits (pi digits from the generator) over a valid/ready handshake and buffers them in a small FIFO.
- On every scroll tick it pops one digit and shifts it into an 8-digit display window. The window drives the scanner's 8 x 4-bit digit input directly.

Parameters:
- DEPTH, 8, FIFO depth in digits; power of two, at least 2.
- SCROLL_DIV, 25000000, clk cycles per scroll tick; at least 2.
- COUNT_W, 16, width of the displayed-digit counter.
- BLANK, 4'd10, code loaded into empty window positions. The scanner renders codes above 9 as blank/dp.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- pause  in  1  high freezes the scroll prescaler; the FIFO keeps accepting.
- in_valid  in  1  in_digit is valid this cycle.
- in_digit  in  4  BCD digit, 0..9.
- in_ready  out  1  block can accept a digit this cycle.
- digits_o  out  32  display window; digit k at [4k+3:4k]; k=0 is the newest digit.
- count_o  out  COUNT_W  number of digits shifted into the window; saturating.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- err_o  out  1  sticky flag: a non-BCD digit was received.

Behaviour:
- Reset: rst is synchronous and active-high; clk is the clock. Reset values:
  - digits_o = all eight positions BLANK.
  - count_o = 0, fifo_level = 0, err_o = 0.
  - Prescaler = 0; FIFO pointers = 0.
  - in_ready = 1 from the first cycle after reset.
- Reset asserted mid-operation discards FIFO contents and the window, and ignores a handshake in the same cycle.
- Handshake: a push occurs when in_valid && in_ready.
  - in_ready = (fifo_level != DEPTH), decoded combinationally from registered occupancy.
  - in_digit must be held stable while in_valid && !in_ready.
- Non-BCD input: a pushed in_digit > 9 is consumed (handshake completes) but not written to the FIFO. err_o is set to 1 and stays 1 until rst.
- Prescaler: counts 0..SCROLL_DIV-1 and wraps to 0.
  - tick = (prescaler == SCROLL_DIV-1) && !pause.
  - While pause = 1 the prescaler holds its value.
- Pop: occurs on a tick when fifo_level (registered, start of cycle) != 0.
  - On pop, the next cycle shows digits_o[k] = old digits_o[k-1] for k = 7..1, and digits_o[0] = the popped digit. The oldest digit (k=7) is discarded.
  - count_o increments on each pop and saturates at 2^COUNT_W-1.
- Tick with an empty FIFO: no shift, count_o unchanged, tick lost. The prescaler wraps normally.
- Simultaneous push and pop: both take effect in the same cycle and fifo_level is unchanged.
  - A digit pushed into an empty FIFO cannot be popped in that same cycle. Minimum latency from push to visibility on digits_o is 2 cycles (push at t, pop at t+1 if tick, visible at t+2).
- Full FIFO: in_ready = 0.
  - A pop in a cycle where the FIFO is full makes in_ready = 1 the next cycle, not the same cycle.
- FIFO pointers wrap modulo DEPTH; ordering is strict FIFO.
- fifo_level range is 0..DEPTH and never exceeds DEPTH.
- All outputs are registered except in_ready.

Test Plan (SCROLL_DIV=4, DEPTH=4, COUNT_W=4):
1. Reset, then idle 10 cycles -> digits_o = 32'hAAAAAAAA, count_o = 0, in_ready = 1, fifo_level = 0; ticks occur with no shift.
2. Push 3,1,4 on consecutive cycles, pause = 0 -> one digit shifts in per 4 cycles. Final digits_o = 32'hAAAAA314, count_o = 3, fifo_level returns to 0.
3. Hold in_valid with digits 1..6 and no pops (pause = 1) -> 4 pushes accepted, fifo_level = 4, in_ready = 0. Release pause: after the first pop in_ready = 1 the next cycle, and digit 5 is accepted.
4. Push digit 12, then digit 7 -> 12 is consumed with err_o = 1 (sticky), fifo_level counts only the 7, and 7 is the next digit displayed.
5. Feed digits 0..9 repeatedly for 20 pops -> window holds the last 8 digits in order; count_o saturates at 15.
6. Assert rst for one cycle while fifo_level = 3 and mid-prescale -> all outputs return to reset values the next cycle; a digit offered during the reset cycle is not stored.
